if_id_skid_stage: RTL

- Parametrised successor to the plain enable-gated IF/ID register.
- Carries PC and instruction from fetch to decode using a valid/ready handshake, instead of a bare write-enable.
- Contains a 2-entry skid (main + skid register), so upstream ready is registered and never combinationally depends on downstream ready.
- Adds synchronous flush for branch/jump squash, NOP bubble insertion and a saturating stall counter for performance monitoring.

---
 rtl/if_id_skid_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake and a 2-entry skid.
// The main register drives decode; the skid register catches the one
// entry that fetch may push while decode is stalled. in_ready is the
// inverse of the skid-valid flop, so it never depends on out_ready
// combinationally. Also provides flush, NOP bubbles and a saturating
// stall counter.
module if_id_skid_stage #(
  parameter int                ADDR_W      = 32,
  parameter int                INS_W       = 32,
  parameter logic [INS_W-1:0]  NOP_INS     = 32'h0000_0000,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [INS_W-1:0]       in_ins,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INS_W-1:0]       out_ins,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   clr_stall_cnt
);

  logic                   r_main_valid;
  logic [ADDR_W-1:0]      r_main_pc;
  logic [INS_W-1:0]       r_main_ins;
  logic                   r_skid_valid;
  logic [ADDR_W-1:0]      r_skid_pc;
  logic [INS_W-1:0]       r_skid_ins;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_in_xfer;
  logic w_main_free;
  logic w_skid_load;
  logic w_stall;
  logic w_cnt_max;

  // Upstream may push only while the skid is empty; that guarantees the
  // skid is never overwritten.
  assign in_ready    = ~r_skid_valid;
  assign w_in_xfer   = in_valid & ~r_skid_valid;
  // Main register may take a new entry when empty or being consumed.
  assign w_main_free = ~r_main_valid | out_ready;
  // A push while decode holds the main entry lands in the skid.
  assign w_skid_load = w_in_xfer & r_main_valid & ~out_ready;
  assign w_stall     = r_main_valid & ~out_ready;
  assign w_cnt_max   = &r_stall_cnt;

  assign out_valid = r_main_valid;
  assign out_pc    = r_main_pc;
  assign out_ins   = r_main_ins;
  assign stall_cnt = r_stall_cnt;

  // Main register: skid has priority over fresh input to keep arrival order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_ins   <= NOP_INS;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_ins   <= NOP_INS;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= r_skid_pc;
        r_main_ins   <= r_skid_ins;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= in_pc;
        r_main_ins   <= in_ins;
      end else begin
        // Bubble: pc keeps its last value, instruction becomes NOP.
        r_main_valid <= 1'b0;
        r_main_ins   <= NOP_INS;
      end
    end
  end

  // Skid register: filled on a stalled push, drained into main when main frees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_ins   <= NOP_INS;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_main_free && r_skid_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= in_pc;
      r_skid_ins   <= in_ins;
    end
  end

  // Saturating stall counter; clear beats increment, flush is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (clr_stall_cnt) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
